// File: rtl/wbu_if.sv
// Write-back unit bus bundle: LSU-side accept handshake with the retiring
// instruction fields, IFU-side next-PC handshake, decode read ports and the
// retired-instruction counter.
interface wbu_if;
    // Upstream (LSU) handshake and instruction fields
    logic        s_valid;
    logic        s_ready;
    logic [31:0] alu_result;
    logic [31:0] mdata;
    logic [31:0] pc;
    logic [31:0] csr_rdata;
    logic [31:0] dnpc;
    logic [4:0]  rd;
    logic        rwen;
    logic [1:0]  wbsel;
    // Downstream (IFU) handshake
    logic        m_valid;
    logic        m_ready;
    logic [31:0] dnpcW;
    // Decode-stage register read ports
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    // Retired-instruction counter
    logic [63:0] retired;

    // The write-back unit side
    modport slave (
        input  s_valid, alu_result, mdata, pc, csr_rdata, dnpc, rd, rwen, wbsel,
        input  m_ready, rs1_addr, rs2_addr,
        output s_ready, m_valid, dnpcW, rs1_data, rs2_data, retired
    );

    // The side driving instructions in and consuming results
    modport master (
        output s_valid, alu_result, mdata, pc, csr_rdata, dnpc, rd, rwen, wbsel,
        output m_ready, rs1_addr, rs2_addr,
        input  s_ready, m_valid, dnpcW, rs1_data, rs2_data, retired
    );
endinterface

// File: rtl/wbu.sv
// Write-back unit: accepts one retiring instruction, selects its write-back
// value, updates the GPR file it owns, then offers the next PC to fetch.
// Three-state sequencer IDLE -> WRITE -> DONE, one instruction in flight.
module wbu #(
    parameter int NR_REG = 32
) (
    input  logic clk,
    input  logic rst,
    wbu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [31:0] alu_reg;
    logic [31:0] mdata_reg;
    logic [31:0] pc_reg;
    logic [31:0] csr_reg;
    logic [31:0] dnpc_reg;
    logic [4:0]  rd_reg;
    logic        rwen_reg;
    logic [1:0]  wbsel_reg;
    logic [63:0] retired_reg;

    logic        accept;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] gpr_val [32];

    assign accept = (state_reg == IDLE) && bus.s_valid;
    assign wr_en  = (state_reg == WRITE) && rwen_reg;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; outputs depend only on state so
    // neither ready nor valid loops back combinationally.
    always_comb begin
        state_next  = state_reg;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = DONE;
            end
            DONE: begin
                bus.m_valid = 1'b1;
                if (bus.m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding registers: sampled only on the accepting edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_reg   <= '0;
            mdata_reg <= '0;
            pc_reg    <= '0;
            csr_reg   <= '0;
            dnpc_reg  <= '0;
            rd_reg    <= '0;
            rwen_reg  <= 1'b0;
            wbsel_reg <= '0;
        end else if (accept) begin
            alu_reg   <= bus.alu_result;
            mdata_reg <= bus.mdata;
            pc_reg    <= bus.pc;
            csr_reg   <= bus.csr_rdata;
            dnpc_reg  <= bus.dnpc;
            rd_reg    <= bus.rd;
            rwen_reg  <= bus.rwen;
            wbsel_reg <= bus.wbsel;
        end
    end

    // Write-back source select; pc+4 wraps naturally at 32 bits
    always_comb begin
        wdata = alu_reg;
        case (wbsel_reg)
            2'd0:    wdata = alu_reg;
            2'd1:    wdata = mdata_reg;
            2'd2:    wdata = pc_reg + 32'd4;
            default: wdata = csr_reg;
        endcase
    end

    // Retired counter: counts completed next-PC handshakes, wraps at 2^64
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_reg <= '0;
        end else if ((state_reg == DONE) && bus.m_ready) begin
            retired_reg <= retired_reg + 64'd1;
        end
    end

    // GPR file: only x1..x(NR_REG-1) exist as storage; x0 and indices past
    // the implemented count are hardwired to zero, which also makes writes
    // to them vanish without a separate range check.
    for (genvar gi = 0; gi < 32; gi++) begin : g_gpr
        if (gi == 0 || gi >= NR_REG) begin : g_zero
            assign gpr_val[gi] = '0;
        end else begin : g_reg
            logic [31:0] q_reg;
            // Architectural register update at the edge leaving WRITE
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    q_reg <= '0;
                end else if (wr_en && (rd_reg == 5'(gi))) begin
                    q_reg <= wdata;
                end
            end
            assign gpr_val[gi] = q_reg;
        end
    end

    assign bus.rs1_data = gpr_val[bus.rs1_addr];
    assign bus.rs2_data = gpr_val[bus.rs2_addr];
    assign bus.dnpcW    = dnpc_reg;
    assign bus.retired  = retired_reg;

endmodule

// File: doc/wbu.md
# wbu

Write-back unit: the stage directly downstream of the load/store unit in the multi-cycle core. It accepts one retiring instruction per valid/ready handshake and selects the write-back value (ALU result, load data, PC+4 or CSR read data). It writes that value into the general-purpose register file, which it owns, and then hands the next PC to the fetch unit over a second valid/ready handshake. It also exposes two combinational register read ports to the decode stage and keeps a retired-instruction counter.

## Interface
- NR_REG, 32: number of GPRs; 32 for RV32I, 16 for RV32E.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- s_valid  in  1  upstream (LSU) holds a valid instruction.
- s_ready  out  1  wbu can accept an instruction.
- alu_result  in  32  ALU result.
- mdata  in  32  load data (already extended).
- pc  in  32  PC of the instruction.
- csr_rdata  in  32  CSR read value.
- dnpc  in  32  next PC computed upstream.
- rd  in  5  destination register index.
- rwen  in  1  register write enable.
- wbsel  in  2  0 = alu_result, 1 = mdata, 2 = pc+4, 3 = csr_rdata.
- m_valid  out  1  next PC valid toward IFU.
- m_ready  in  1  IFU accepts next PC.
- dnpcW  out  32  latched next PC.
- rs1_addr, rs2_addr  in  5 each  decode read indices.
- rs1_data, rs2_data  out  32 each  combinational GPR read data.
- retired  out  64  count of completed m_valid/m_ready handshakes.

## Operation
- FSM states are IDLE, WRITE and DONE.
  - IDLE: s_ready=1. On s_valid, latch alu_result, mdata, pc, csr_rdata, dnpc, rd, rwen, wbsel into holding registers, then go to WRITE. Without s_valid, stay in IDLE.
  - WRITE: s_ready=0, m_valid=0. Compute wdata from the latched wbsel. At the rising edge that leaves WRITE, write gpr[rd]=wdata iff rwen=1, rd!=0 and rd<NR_REG. Always go to DONE.
  - DONE: m_valid=1, dnpcW = latched dnpc. On m_ready, increment retired and go to IDLE. Otherwise hold every output stable.
  - Any other encoding goes to IDLE.
- pc+4 is computed mod 2^32: 0xFFFF_FFFC gives 0x0000_0000.
- retired wraps from 2^64-1 to 0.
- GPR file:
  - x0 always reads 0 and is never written.
  - A read index >= NR_REG returns 0.
  - Reads are combinational from architectural state, with no write bypass. A register written in WRITE is visible from the first DONE cycle onward.
- Inputs other than s_valid are sampled only on the accepting edge. Changes afterwards are ignored.

## Timing
- Reset (rst=0), taking effect immediately:
  - state goes to IDLE, so s_ready=1 and m_valid=0.
  - dnpcW=0, retired=0, all holding registers 0, all GPRs 0.
- Reset mid-operation:
  - If rst falls while in WRITE, before the edge, no GPR write occurs.
  - If rst falls in DONE, the pending handshake is dropped and retired is not incremented.
- Latency, with edge 0 accepting:
  - WRITE occupies cycle 1.
  - The GPR update and entry into DONE happen at edge 1.
  - m_valid is high from cycle 2.
  - Minimum handshake-to-handshake throughput is 3 cycles per instruction, because s_ready is low in WRITE and DONE.
- m_ready high during IDLE or WRITE has no effect.
- m_valid never depends combinationally on m_ready. s_ready never depends combinationally on s_valid.

## Test plan
- Reset:
  - Stimulus: assert rst=0 asynchronously mid-cycle.
  - Required response: s_ready=1, m_valid=0 and retired=0 immediately; rs1_addr=5 reads 0.
- ALU write-back:
  - Stimulus: s_valid with wbsel=0, alu_result=0x1234_5678, rd=5, rwen=1, dnpc=0x8000_0004; m_ready held 1.
  - Required response: m_valid high in cycle 2 with dnpcW=0x8000_0004; rs1_data(5)=0x1234_5678 from cycle 2; retired=1 after the handshake.
- Source selection and x0:
  - Stimulus 1: wbsel=1, mdata=0xFFFF_FF80, rd=0.
  - Required response 1: x0 still reads 0.
  - Stimulus 2: wbsel=2, pc=0xFFFF_FFFC, rd=3.
  - Required response 2: x3=0.
  - Stimulus 3: wbsel=3, csr_rdata=0xDEAD_BEEF, rd=31.
  - Required response 3: x31=0xDEAD_BEEF.
- Backpressure:
  - Stimulus: hold m_ready=0 for 5 cycles in DONE; change upstream inputs and pulse s_valid meanwhile.
  - Required response: m_valid and dnpcW stable; s_ready=0; no new capture; retired unchanged until the m_ready cycle.
- Write enable and RV32E:
  - Stimulus 1: rwen=0 with rd=7.
  - Required response 1: x7 unchanged.
  - Stimulus 2: with NR_REG=16, write rd=20.
  - Required response 2: no write occurs; reading index 20 returns 0.
- Reset in WRITE:
  - Stimulus: rst=0 during the WRITE cycle of an instruction targeting x9.
  - Required response: x9=0, state IDLE, retired unchanged.
